pwm_gen: RTL and testbench
==========================

// Module: pwm_gen
// PURPOSE
//  Output-direction companion to the 16-bit input-counting timer: drives a PWM / one-shot
//  waveform instead of counting input edges. CPU I/O register interface matches the timer
//  (16-bit regs with per-byte write strobes, 8-bit config). Sits on the peripheral bus; pwm_out to a pin.
// PARAMETERS
//  RESET_POL  1'b0  inactive output level after reset, before config is written
// PORTS
//  clk              in   1   system clock; single clock domain
//  reset            in   1   asynchronous, active-high; clears all state
//  counter_in       in   16  counter write data
//  counter_write    in   2   byte strobes [0]=low, [1]=high
//  period_in/duty_in in  16  period / duty write data (to buffer regs)
//  period_write/duty_write in 2  byte strobes
//  config_in        in   8   config write data;  config_write in 1  strobe
//  counter_out/period_out/duty_out out 16  readback (buffer values for period/duty)
//  config_out       out  8   readback (bit0 reflects hardware clear)
//  period_int       out  1   one-cycle pulse at period wrap
//  pwm_out          out  1   registered waveform
//  pwm_n_out        out  1   complementary waveform
// BEHAVIOUR
//  Config: [0] EN, [1] ONESHOT, [2] POL (1=active-low), [5:4] prescale /1,/4,/16,/64, [7:6] rsvd (read 0).
//  Reset: all regs 0, state IDLE, period_int=0, pwm_out=RESET_POL, pwm_n_out=~RESET_POL.
//  FSM IDLE->RUN: EN seen 1 in IDLE. Entry cycle: presc=0, counter=0, active period/duty <- buffers.
//  FSM RUN->IDLE: EN written 0 (next cycle), or wrap with ONESHOT=1 (hw clears EN same edge).
//  IDLE: counter held, no ticks, output inactive (= POL).
//  Prescaler: 6-bit, increments every RUN cycle; tick when selected low bits (0/2/4/6) are zero.
//  Tick: counter==active_period -> counter=0, period_int=1, active regs <- buffers (wrap);
//   else counter+1. Period P gives P+1 ticks per cycle; P=0 -> wrap every tick.
//  Raw active = (counter < active_duty); duty=0 never active; duty>P always active (no glitch).
//  pwm_out = raw ^ POL, registered: 1 clk latency after counter update.
//  Counter byte writes override tick increment same cycle; writing counter > period runs to
//   16'hffff then wraps to 0 (wrap event as normal, period_int pulses).
//  Period/duty writes touch buffer only; torn byte writes straddling a wrap are software's problem.
//  config_write with EN=1 in RUN: prescaler/ONESHOT/POL changes apply next cycle, no restart.
//  Simultaneous hw EN clear and config_write: written value wins.
//  Async reset mid-period: outputs to reset values immediately, no period_int.
// CONFIGURATION
//  DEADTIME_EN defined: adds deadtime_in/deadtime_out (8), deadtime_write (1). On each raw edge
//   both outputs inactive for D clk cycles, then the new output asserts; D=0 -> pure complement.
//   Pulse shorter than D is suppressed entirely on that output.
//  Not defined: ports absent; pwm_n_out = ~pwm_out, same cycle.
// STRUCTURE
//  timer_pkg: config bit index localparams, prescale encoding enum, pwm_state_t {IDLE,RUN}.
//  Sub-module pwm_deadtime (only under DEADTIME_EN): raw in, D in, pwm/pwm_n out, 8-bit down-counter.
// TESTING
//  1. P=4, duty=2, /1, EN: pwm_out high 2 clk low 3 clk, period_int every 5 clk.
//  2. duty=0 -> pwm_out constant 0; duty=5, P=4 -> constant 1; POL=1 inverts both.
//  3. Write duty=3 mid-period, P=9: current period unchanged, next period 3 high.
//  4. ONESHOT, P=7: one pulse, single period_int, config_out[0] reads 0, output returns inactive.
//  5. Prescale /4, P=1: counter changes every 4 clk; reset asserted mid-run -> all outputs reset async.
//  6. DEADTIME_EN, D=2, P=9, duty=5: 2-clk gap with both outputs low at each transition.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer / PWM peripheral family: config bit layout,
// prescale encoding, PWM state encoding and small register helpers.
package timer_pkg;

  // Config register bit positions
  localparam int unsigned CFG_EN       = 0;
  localparam int unsigned CFG_ONESHOT  = 1;
  localparam int unsigned CFG_POL      = 2;
  localparam int unsigned CFG_PRESC_LO = 4;
  localparam int unsigned CFG_PRESC_HI = 5;

  // Bits [7:6] are reserved and always read back as zero
  localparam logic [7:0] CFG_WRITE_MASK = 8'h3f;

  typedef enum logic [1:0] {
    PrescDiv1  = 2'd0,
    PrescDiv4  = 2'd1,
    PrescDiv16 = 2'd2,
    PrescDiv64 = 2'd3
  } presc_sel_t;

  typedef logic [0:0] pwm_state_t;
  localparam pwm_state_t IDLE = 1'b0;
  localparam pwm_state_t RUN  = 1'b1;

  // Prescaler bits that must all be zero for a tick
  function automatic logic [5:0] presc_mask(input presc_sel_t sel);
    presc_mask = 6'h00;
    unique case (sel)
      PrescDiv1:  presc_mask = 6'h00;
      PrescDiv4:  presc_mask = 6'h03;
      PrescDiv16: presc_mask = 6'h0f;
      PrescDiv64: presc_mask = 6'h3f;
    endcase
  endfunction

  function automatic logic [15:0] byte_merge(input logic [15:0] cur,
                                             input logic [15:0] wdata,
                                             input logic [1:0]  strb);
    byte_merge = cur;
    if (strb[0]) byte_merge[7:0]  = wdata[7:0];
    if (strb[1]) byte_merge[15:8] = wdata[15:8];
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Deadtime inserter for pwm_gen: both outputs go inactive for D clocks on every
// raw edge before the new side asserts. Only built when DEADTIME_EN is defined.
`ifdef DEADTIME_EN
module pwm_deadtime #(
  parameter logic RESET_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  input  logic       pol,
  input  logic [7:0] deadtime,
  output logic       pwm,
  output logic       pwm_n
);

  logic       target_q, target_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pwm_q, pwm_d;
  logic       pwm_n_q, pwm_n_d;

  // A raw edge arriving while a gap is still counting restarts the gap, so a
  // pulse shorter than D never reaches its output.
  always_comb begin
    target_d = raw;
    cnt_d    = cnt_q;
    if (raw != target_q) begin
      cnt_d = deadtime;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
    pwm_d   = ((cnt_d == 8'd0) &  target_d) ^ pol;
    pwm_n_d = ((cnt_d == 8'd0) & ~target_d) ^ pol;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q <= 1'b0;
      cnt_q    <= 8'd0;
      pwm_q    <= RESET_POL;
      pwm_n_q  <= ~RESET_POL;
    end else begin
      target_q <= target_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      pwm_n_q  <= pwm_n_d;
    end
  end

  assign pwm   = pwm_q;
  assign pwm_n = pwm_n_q;

endmodule
`endif

// File: rtl/pwm_gen.sv
// PWM / one-shot generator with timer-compatible CPU register interface.
// Optional deadtime insertion on pwm_out/pwm_n_out when DEADTIME_EN is defined.
module pwm_gen
  import timer_pkg::*;
#(
  parameter logic RESET_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] counter_in,
  input  logic [1:0]  counter_write,
  input  logic [15:0] period_in,
  input  logic [1:0]  period_write,
  input  logic [15:0] duty_in,
  input  logic [1:0]  duty_write,
  input  logic [7:0]  config_in,
  input  logic        config_write,
`ifdef DEADTIME_EN
  input  logic [7:0]  deadtime_in,
  input  logic        deadtime_write,
  output logic [7:0]  deadtime_out,
`endif
  output logic [15:0] counter_out,
  output logic [15:0] period_out,
  output logic [15:0] duty_out,
  output logic [7:0]  config_out,
  output logic        period_int,
  output logic        pwm_out,
  output logic        pwm_n_out
);

  logic [15:0] counter_q, counter_d;
  logic [15:0] period_buf_q, period_buf_d;
  logic [15:0] duty_buf_q, duty_buf_d;
  logic [15:0] period_act_q, period_act_d;
  logic [15:0] duty_act_q, duty_act_d;
  logic [7:0]  cfg_q, cfg_d;
  logic        cfg_seen_q, cfg_seen_d;
  pwm_state_t  state_q, state_d;
  logic [5:0]  presc_q, presc_d;
  logic        period_int_q, period_int_d;

  logic        tick;
  logic        wrap;
  logic        raw_active;
  logic        pol_eff;

  // Until software has written config, the idle level is the build-time RESET_POL
  assign pol_eff = cfg_seen_q ? cfg_q[CFG_POL] : RESET_POL;

  always_comb begin
    tick       = (state_q == RUN) &&
                 ((presc_q & presc_mask(presc_sel_t'(cfg_q[CFG_PRESC_HI:CFG_PRESC_LO]))) == 6'd0);
    // A counter written above the period runs out to 16'hffff and wraps there
    wrap       = tick && ((counter_q == period_act_q) || (counter_q == 16'hffff));
    raw_active = (state_q == RUN) && (counter_q < duty_act_q);
  end

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    presc_d      = presc_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    period_int_d = 1'b0;
    cfg_d        = cfg_q;

    case (state_q)
      IDLE: begin
        if (cfg_q[CFG_EN]) begin
          state_d      = RUN;
          presc_d      = 6'd0;
          counter_d    = 16'd0;
          period_act_d = period_buf_q;
          duty_act_d   = duty_buf_q;
        end
      end
      RUN: begin
        if (!cfg_q[CFG_EN]) begin
          state_d = IDLE;
        end else begin
          presc_d = presc_q + 6'd1;
          if (wrap) begin
            counter_d    = 16'd0;
            period_int_d = 1'b1;
            period_act_d = period_buf_q;
            duty_act_d   = duty_buf_q;
            if (cfg_q[CFG_ONESHOT]) begin
              cfg_d[CFG_EN] = 1'b0;
              state_d       = IDLE;
            end
          end else if (tick) begin
            counter_d = counter_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Software writes take priority over hardware updates in the same cycle
    counter_d    = byte_merge(counter_d, counter_in, counter_write);
    period_buf_d = byte_merge(period_buf_q, period_in, period_write);
    duty_buf_d   = byte_merge(duty_buf_q, duty_in, duty_write);
    if (config_write) begin
      cfg_d = config_in & CFG_WRITE_MASK;
    end
    cfg_seen_d = cfg_seen_q | config_write;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q    <= 16'd0;
      period_buf_q <= 16'd0;
      duty_buf_q   <= 16'd0;
      period_act_q <= 16'd0;
      duty_act_q   <= 16'd0;
      cfg_q        <= 8'd0;
      cfg_seen_q   <= 1'b0;
      state_q      <= IDLE;
      presc_q      <= 6'd0;
      period_int_q <= 1'b0;
    end else begin
      counter_q    <= counter_d;
      period_buf_q <= period_buf_d;
      duty_buf_q   <= duty_buf_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      cfg_q        <= cfg_d;
      cfg_seen_q   <= cfg_seen_d;
      state_q      <= state_d;
      presc_q      <= presc_d;
      period_int_q <= period_int_d;
    end
  end

`ifdef DEADTIME_EN
  logic [7:0] deadtime_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deadtime_q <= 8'd0;
    end else if (deadtime_write) begin
      deadtime_q <= deadtime_in;
    end
  end

  assign deadtime_out = deadtime_q;

  pwm_deadtime #(
    .RESET_POL(RESET_POL)
  ) u_deadtime (
    .clk      (clk),
    .reset    (reset),
    .raw      (raw_active),
    .pol      (pol_eff),
    .deadtime (deadtime_q),
    .pwm      (pwm_out),
    .pwm_n    (pwm_n_out)
  );
`else
  logic pwm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q <= RESET_POL;
    end else begin
      pwm_q <= raw_active ^ pol_eff;
    end
  end

  assign pwm_out   = pwm_q;
  assign pwm_n_out = ~pwm_q;
`endif

  assign counter_out = counter_q;
  assign period_out  = period_buf_q;
  assign duty_out    = duty_buf_q;
  assign config_out  = cfg_q;
  assign period_int  = period_int_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed self-checking bench for pwm_gen; the deadtime scenario is only
// exercised when DEADTIME_EN is defined.
module tb_pwm_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] counter_in, period_in, duty_in;
  logic [1:0]  counter_write, period_write, duty_write;
  logic [7:0]  config_in;
  logic        config_write;
  logic [15:0] counter_out, period_out, duty_out;
  logic [7:0]  config_out;
  logic        period_int, pwm_out, pwm_n_out;
`ifdef DEADTIME_EN
  logic [7:0]  deadtime_in, deadtime_out;
  logic        deadtime_write;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  pwm_gen #(
    .RESET_POL(1'b0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .counter_in    (counter_in),
    .counter_write (counter_write),
    .period_in     (period_in),
    .period_write  (period_write),
    .duty_in       (duty_in),
    .duty_write    (duty_write),
    .config_in     (config_in),
    .config_write  (config_write),
`ifdef DEADTIME_EN
    .deadtime_in   (deadtime_in),
    .deadtime_write(deadtime_write),
    .deadtime_out  (deadtime_out),
`endif
    .counter_out   (counter_out),
    .period_out    (period_out),
    .duty_out      (duty_out),
    .config_out    (config_out),
    .period_int    (period_int),
    .pwm_out       (pwm_out),
    .pwm_n_out     (pwm_n_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sel: 0 counter, 1 period, 2 duty, 3 config, 4 deadtime
  task automatic bus_write(input int sel, input logic [15:0] data, input logic [1:0] strb);
    case (sel)
      0: begin counter_in = data; counter_write = strb; end
      1: begin period_in = data; period_write = strb; end
      2: begin duty_in = data; duty_write = strb; end
      3: begin config_in = data[7:0]; config_write = 1'b1; end
`ifdef DEADTIME_EN
      4: begin deadtime_in = data[7:0]; deadtime_write = 1'b1; end
`endif
      default: ;
    endcase
    @(posedge clk);
    #1;
    counter_write = 2'b00;
    period_write  = 2'b00;
    duty_write    = 2'b00;
    config_write  = 1'b0;
`ifdef DEADTIME_EN
    deadtime_write = 1'b0;
`endif
  endtask

  // Leaves the bench at the negedge sample where period_int is high
  task automatic wait_pi(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = period_int;
    end
    check_eq({tag, "_pi_timeout"}, {31'd0, seen}, 32'd1);
  endtask

  // Prescale /1 steady-state waveform: sample k shows the output for the
  // counter value held at sample k-1.
  task automatic check_wave(input string tag, input int p, input int duty, input logic pol,
                            input int n);
    int   prev;
    logic exp;
    wait_pi({tag, "_s0"});
    wait_pi({tag, "_s1"});
    wait_pi({tag, "_s2"});
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      prev = (k == 0) ? p : (k - 1) % (p + 1);
      exp  = (prev < duty) ^ pol;
      check_eq($sformatf("%s_pwm%0d", tag, k), {31'd0, pwm_out}, {31'd0, exp});
      check_eq($sformatf("%s_pwmn%0d", tag, k), {31'd0, pwm_n_out}, {31'd0, !exp});
      check_eq($sformatf("%s_pi%0d", tag, k), {31'd0, period_int},
               {31'd0, ((k % (p + 1)) == 0)});
    end
  endtask

  initial begin
    int   prev, d, pi_cnt, hi_cnt;
    logic exp;

    reset = 1'b1;
    counter_in = '0; period_in = '0; duty_in = '0; config_in = '0;
    counter_write = '0; period_write = '0; duty_write = '0; config_write = 1'b0;
`ifdef DEADTIME_EN
    deadtime_in = '0; deadtime_write = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_counter", {16'd0, counter_out}, 32'd0);
    check_eq("rst_period", {16'd0, period_out}, 32'd0);
    check_eq("rst_duty", {16'd0, duty_out}, 32'd0);
    check_eq("rst_config", {24'd0, config_out}, 32'd0);
    check_eq("rst_pwm", {31'd0, pwm_out}, 32'd0);
    check_eq("rst_pwmn", {31'd0, pwm_n_out}, 32'd1);
    check_eq("rst_pi", {31'd0, period_int}, 32'd0);

    // Byte strobes, reserved config bits, counter write held in IDLE
    bus_write(1, 16'hab12, 2'b10);
    check_eq("per_hi_byte", {16'd0, period_out}, 32'h0000ab00);
    bus_write(1, 16'h3434, 2'b01);
    check_eq("per_lo_byte", {16'd0, period_out}, 32'h0000ab34);
    bus_write(3, 16'h00c0, 2'b00);
    check_eq("cfg_rsvd", {24'd0, config_out}, 32'd0);
    bus_write(0, 16'h1234, 2'b11);
    repeat (3) @(negedge clk);
    check_eq("idle_counter_hold", {16'd0, counter_out}, 32'h1234);

    // 1: P=4, duty=2, /1
    bus_write(1, 16'd4, 2'b11);
    bus_write(2, 16'd2, 2'b11);
    bus_write(3, 16'h0001, 2'b00);
    check_wave("t1", 4, 2, 1'b0, 10);

    // 2: duty=0, duty>P, then POL=1
    bus_write(2, 16'd0, 2'b11);
    check_wave("t2_d0", 4, 0, 1'b0, 10);
    bus_write(2, 16'd5, 2'b11);
    check_wave("t2_d5", 4, 5, 1'b0, 10);
    bus_write(3, 16'h0005, 2'b00);
    check_wave("t2_pol_d5", 4, 5, 1'b1, 10);
    bus_write(2, 16'd2, 2'b11);
    check_wave("t2_pol_d2", 4, 2, 1'b1, 10);

    // 3: duty change mid-period only affects the following period
    bus_write(3, 16'h0000, 2'b00);
    repeat (3) @(negedge clk);
    bus_write(1, 16'd9, 2'b11);
    bus_write(2, 16'd6, 2'b11);
    bus_write(3, 16'h0001, 2'b00);
    wait_pi("t3");
    for (int k = 0; k < 21; k++) begin
      prev = (k == 0) ? 9 : (k - 1) % 10;
      d    = (k <= 10) ? 6 : 3;
      exp  = (prev < d);
      check_eq($sformatf("t3_pwm%0d", k), {31'd0, pwm_out}, {31'd0, exp});
      if (k == 3) begin
        duty_in    = 16'd3;
        duty_write = 2'b11;
      end
      @(posedge clk);
      #1;
      duty_write = 2'b00;
      @(negedge clk);
    end

    // 4: one-shot, P=7, duty=3
    bus_write(3, 16'h0000, 2'b00);
    repeat (3) @(negedge clk);
    bus_write(1, 16'd7, 2'b11);
    bus_write(2, 16'd3, 2'b11);
    bus_write(3, 16'h0003, 2'b00);
    pi_cnt = 0;
    hi_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      pi_cnt += int'(period_int);
      hi_cnt += int'(pwm_out);
    end
    check_eq("t4_pi_count", pi_cnt, 32'd1);
    check_eq("t4_high_cycles", hi_cnt, 32'd3);
    check_eq("t4_cfg_en_clr", {24'd0, config_out}, 32'h02);
    check_eq("t4_pwm_idle", {31'd0, pwm_out}, 32'd0);
    check_eq("t4_pwmn_idle", {31'd0, pwm_n_out}, 32'd1);
    check_eq("t4_counter_idle", {16'd0, counter_out}, 32'd0);

    // 5: prescale /4, P=1, duty>P; async reset while output and period_int are high
    bus_write(1, 16'd1, 2'b11);
    bus_write(2, 16'd2, 2'b11);
    bus_write(3, 16'h0011, 2'b00);
    wait_pi("t5");
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check_eq($sformatf("t5_cnt%0d", k), {16'd0, counter_out}, (k / 4) % 2);
      check_eq($sformatf("t5_pi%0d", k), {31'd0, period_int}, {31'd0, (k == 0)});
    end
    @(negedge clk);
    check_eq("t5_pre_pwm", {31'd0, pwm_out}, 32'd1);
    check_eq("t5_pre_pi", {31'd0, period_int}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_rst_pwm", {31'd0, pwm_out}, 32'd0);
    check_eq("t5_rst_pwmn", {31'd0, pwm_n_out}, 32'd1);
    check_eq("t5_rst_pi", {31'd0, period_int}, 32'd0);
    check_eq("t5_rst_counter", {16'd0, counter_out}, 32'd0);
    check_eq("t5_rst_config", {24'd0, config_out}, 32'd0);
    check_eq("t5_rst_period", {16'd0, period_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

`ifdef DEADTIME_EN
    // 6: D=2, P=9, duty=5
    bus_write(4, 16'd2, 2'b00);
    check_eq("t6_dt_readback", {24'd0, deadtime_out}, 32'd2);
    bus_write(1, 16'd9, 2'b11);
    bus_write(2, 16'd5, 2'b11);
    bus_write(3, 16'h0001, 2'b00);
    wait_pi("t6_s0");
    wait_pi("t6_s1");
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      d = k % 10;
      check_eq($sformatf("t6_pwm%0d", k), {31'd0, pwm_out}, {31'd0, (d >= 3 && d <= 5)});
      check_eq($sformatf("t6_pwmn%0d", k), {31'd0, pwm_n_out}, {31'd0, (d >= 8 || d == 0)});
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
